imem_boot_ctrl: RTL and testbench

Sequences the single-cycle core between program-load and execution. Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into the instruction RAM at consecutive word addresses. Releases the core's reset and register-file enable once loading completes, and freezes the core on a halt request. Sits between the external loader interface and the instruction RAM, counter and register-file control inputs of the core top level.

---
 rtl/imem_boot_ctrl.sv | 145 ++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// Purpose: sequences the core between instruction-RAM program load and execution.
// Latency: each accepted word is written to RAM on the next edge; RUN follows the last write after one DRAIN cycle.
// Backpressure: in_ready is high only in LOAD and drops on the edge that accepts the final word.
//
// Ports:
//   clk, rst              - system clock, synchronous active-high reset
//   start, load_len       - begin-load pulse and word count (clamped to DEPTH), honoured in IDLE/HALT
//   in_valid/in_ready/in_data - instruction word stream from the external loader
//   halt_req              - level request to freeze the core, honoured in RUN only
//   mem_rw/mem_addr/mem_wdata - instruction RAM write port
//   core_rst, core_en     - core PC/register-file reset and register-file write enable
//   busy, done, load_count - status: loading, halted, words written since last start
module imem_boot_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  input  logic              halt_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              core_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   load_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    RUN,
    HALT
  } stateT;

  localparam logic [ADDR_W:0] depthMax = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] countOne = {{ADDR_W{1'b0}}, 1'b1};

  stateT           state;
  logic [ADDR_W:0] lenReg;
  logic [ADDR_W:0] clampedLen;
  logic [ADDR_W:0] nextCount;
  logic            xfer;

  // Clamping the length to the RAM depth is what keeps mem_addr from wrapping.
  always_comb begin
    clampedLen = load_len;
    if (load_len > depthMax) begin
      clampedLen = depthMax;
    end
    nextCount = load_count + countOne;
    xfer      = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lenReg     <= '0;
      in_ready   <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst   <= 1'b1;
      core_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_count <= '0;
    end else begin
      case (state)
        // HALT shares the start path with IDLE; halt_req is not looked at here.
        IDLE, HALT: begin
          if (start) begin
            lenReg     <= clampedLen;
            load_count <= '0;
            done       <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            if (clampedLen == '0) begin
              // Nothing to load: run whatever image is already in RAM.
              state    <= RUN;
              core_rst <= 1'b0;
              core_en  <= 1'b1;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              core_rst <= 1'b1;
              core_en  <= 1'b0;
            end
          end
        end

        LOAD: begin
          if (xfer) begin
            mem_rw     <= 1'b1;
            mem_addr   <= load_count[ADDR_W-1:0];
            mem_wdata  <= in_data;
            load_count <= nextCount;
            if (nextCount == lenReg) begin
              in_ready <= 1'b0;
              busy     <= 1'b0;
              state    <= DRAIN;
            end
          end else begin
            // Idle beat: no write, address holds.
            mem_rw <= 1'b0;
          end
        end

        // The final write pulse is on the RAM port during this cycle; the
        // core is only released once it has landed.
        DRAIN: begin
          mem_rw   <= 1'b0;
          mem_addr <= '0;
          core_rst <= 1'b0;
          core_en  <= 1'b1;
          state    <= RUN;
        end

        // RAM port is parked at address 0 with no write so fetch owns it.
        RUN: begin
          mem_rw   <= 1'b0;
          mem_addr <= '0;
          if (halt_req) begin
            core_en <= 1'b0;
            done    <= 1'b1;
            state   <= HALT;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
module tb_imem_boot_ctrl;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef struct {
    logic        rst;
    logic        start;
    logic [5:0]  len;
    logic        halt;
    logic        vld;
    logic [31:0] dat;
    logic        eRdy;
    logic        eRw;
    logic [4:0]  eAddr;
    logic [31:0] eWdata;
    logic        eCrst;
    logic        eCen;
    logic        eBusy;
    logic        eDone;
    logic [5:0]  eCnt;
  } vecT;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  load_len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        halt_req;
  logic        mem_rw;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        core_en;
  logic        busy;
  logic        done;
  logic [5:0]  load_count;

  int nChecks;
  int nFails;
  int rowNo;
  string phase;
  vecT vecs[$];

  imem_boot_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_len   (load_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .halt_req   (halt_req),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst   (core_rst),
    .core_en    (core_en),
    .busy       (busy),
    .done       (done),
    .load_count (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s %s row %0d: got %h, expected %h", phase, name, rowNo, act, exp);
    end
  endtask

  function automatic vecT mk(input logic r, input logic s, input logic [5:0] l,
                             input logic h, input logic v, input logic [31:0] d,
                             input logic rdy, input logic rw, input logic [4:0] a,
                             input logic [31:0] wd, input logic crst, input logic cen,
                             input logic bsy, input logic dn, input logic [5:0] cnt);
    vecT t;
    t.rst = r;   t.start = s;  t.len = l;    t.halt = h;  t.vld = v;  t.dat = d;
    t.eRdy = rdy; t.eRw = rw;  t.eAddr = a;  t.eWdata = wd;
    t.eCrst = crst; t.eCen = cen; t.eBusy = bsy; t.eDone = dn; t.eCnt = cnt;
    return t;
  endfunction

  // Drive one cycle of inputs, clock once, then compare every output.
  task automatic applyRow(input vecT t);
    rst      = t.rst;
    start    = t.start;
    load_len = t.len;
    halt_req = t.halt;
    in_valid = t.vld;
    in_data  = t.dat;
    @(posedge clk);
    #1;
    chk("in_ready",   {31'd0, in_ready},  {31'd0, t.eRdy});
    chk("mem_rw",     {31'd0, mem_rw},    {31'd0, t.eRw});
    chk("mem_addr",   {27'd0, mem_addr},  {27'd0, t.eAddr});
    chk("mem_wdata",  mem_wdata,          t.eWdata);
    chk("core_rst",   {31'd0, core_rst},  {31'd0, t.eCrst});
    chk("core_en",    {31'd0, core_en},   {31'd0, t.eCen});
    chk("busy",       {31'd0, busy},      {31'd0, t.eBusy});
    chk("done",       {31'd0, done},      {31'd0, t.eDone});
    chk("load_count", {26'd0, load_count},{26'd0, t.eCnt});
    rowNo++;
  endtask

  localparam logic [31:0] D1 = 32'h0050_0093;
  localparam logic [31:0] D2 = 32'h00A0_0113;
  localparam logic [31:0] D3 = 32'h0020_81B3;
  localparam logic [31:0] D4 = 32'h0000_006F;

  initial begin
    logic [31:0] w;
    nChecks = 0;
    nFails  = 0;
    rowNo   = 0;
    rst = 1'b1; start = 1'b0; load_len = '0; halt_req = 1'b0;
    in_valid = 1'b0; in_data = '0;

    //        rst st len  hl vl dat            | rdy rw adr wdata          crs cen bsy dn cnt
    vecs.push_back(mk(1, 0, 6'd0, 0, 0, 32'h0,        0, 0, 5'd0, 32'h0,        1, 0, 0, 0, 6'd0));
    vecs.push_back(mk(1, 0, 6'd0, 0, 0, 32'h0,        0, 0, 5'd0, 32'h0,        1, 0, 0, 0, 6'd0));
    // four-word load, in_valid held high
    vecs.push_back(mk(0, 1, 6'd4, 0, 1, D1,           1, 0, 5'd0, 32'h0,        1, 0, 1, 0, 6'd0));
    vecs.push_back(mk(0, 0, 6'd0, 0, 1, D1,           1, 1, 5'd0, D1,           1, 0, 1, 0, 6'd1));
    vecs.push_back(mk(0, 0, 6'd0, 0, 1, D2,           1, 1, 5'd1, D2,           1, 0, 1, 0, 6'd2));
    vecs.push_back(mk(0, 0, 6'd0, 0, 1, D3,           1, 1, 5'd2, D3,           1, 0, 1, 0, 6'd3));
    vecs.push_back(mk(0, 0, 6'd0, 0, 1, D4,           0, 1, 5'd3, D4,           1, 0, 0, 0, 6'd4));
    vecs.push_back(mk(0, 0, 6'd0, 0, 1, 32'hFFFFFFFF, 0, 0, 5'd0, D4,           0, 1, 0, 0, 6'd4));
    vecs.push_back(mk(0, 0, 6'd0, 0, 0, 32'h0,        0, 0, 5'd0, D4,           0, 1, 0, 0, 6'd4));
    // halt, release halt_req (stays halted), restart with len 0, start ignored in RUN
    vecs.push_back(mk(0, 0, 6'd0, 1, 0, 32'h0,        0, 0, 5'd0, D4,           0, 0, 0, 1, 6'd4));
    vecs.push_back(mk(0, 0, 6'd0, 0, 0, 32'h0,        0, 0, 5'd0, D4,           0, 0, 0, 1, 6'd4));
    vecs.push_back(mk(0, 1, 6'd0, 0, 0, 32'h0,        0, 0, 5'd0, D4,           0, 1, 0, 0, 6'd0));
    vecs.push_back(mk(0, 1, 6'd3, 0, 1, 32'h0,        0, 0, 5'd0, D4,           0, 1, 0, 0, 6'd0));
    vecs.push_back(mk(0, 0, 6'd0, 1, 0, 32'h0,        0, 0, 5'd0, D4,           0, 0, 0, 1, 6'd0));
    // start from HALT with halt_req still high; three words with gaps
    vecs.push_back(mk(0, 1, 6'd3, 1, 1, 32'h11111111, 1, 0, 5'd0, D4,           1, 0, 1, 0, 6'd0));
    vecs.push_back(mk(0, 0, 6'd0, 0, 1, 32'h11111111, 1, 1, 5'd0, 32'h11111111, 1, 0, 1, 0, 6'd1));
    vecs.push_back(mk(0, 0, 6'd0, 0, 0, 32'h22222222, 1, 0, 5'd0, 32'h11111111, 1, 0, 1, 0, 6'd1));
    vecs.push_back(mk(0, 1, 6'd7, 0, 0, 32'h22222222, 1, 0, 5'd0, 32'h11111111, 1, 0, 1, 0, 6'd1));
    vecs.push_back(mk(0, 0, 6'd0, 0, 1, 32'h33333333, 1, 1, 5'd1, 32'h33333333, 1, 0, 1, 0, 6'd2));
    vecs.push_back(mk(0, 0, 6'd0, 0, 1, 32'h44444444, 0, 1, 5'd2, 32'h44444444, 1, 0, 0, 0, 6'd3));
    vecs.push_back(mk(0, 0, 6'd0, 0, 0, 32'h0,        0, 0, 5'd0, 32'h44444444, 0, 1, 0, 0, 6'd3));
    vecs.push_back(mk(0, 0, 6'd0, 1, 0, 32'h0,        0, 0, 5'd0, 32'h44444444, 0, 0, 0, 1, 6'd3));
    // oversize length is clamped to DEPTH
    vecs.push_back(mk(0, 1, 6'd40, 0, 0, 32'h0,       1, 0, 5'd0, 32'h44444444, 1, 0, 1, 0, 6'd0));

    phase = "table";
    foreach (vecs[i]) applyRow(vecs[i]);

    // 32 back-to-back words at addresses 0..31
    phase = "clamp";
    for (int i = 0; i < DEPTH; i++) begin
      w = 32'hA500_0000 + 32'(i);
      applyRow(mk(0, 0, 6'd0, 0, 1, w, (i < DEPTH-1), 1, 5'(i), w,
                  1, 0, (i < DEPTH-1), 0, 6'(i+1)));
    end
    // loader still offering data: no further write, address parks at 0
    applyRow(mk(0, 0, 6'd0, 0, 1, 32'hDEADBEEF, 0, 0, 5'd0, 32'hA500_001F, 0, 1, 0, 0, 6'd32));

    // reset in the middle of a five-word load, then a one-word load
    phase = "abort";
    applyRow(mk(0, 0, 6'd0, 1, 0, 32'h0,        0, 0, 5'd0, 32'hA500_001F, 0, 0, 0, 1, 6'd32));
    applyRow(mk(0, 1, 6'd5, 0, 0, 32'h0,        1, 0, 5'd0, 32'hA500_001F, 1, 0, 1, 0, 6'd0));
    applyRow(mk(0, 0, 6'd0, 0, 1, 32'h0BAD0001, 1, 1, 5'd0, 32'h0BAD0001, 1, 0, 1, 0, 6'd1));
    applyRow(mk(0, 0, 6'd0, 0, 1, 32'h0BAD0002, 1, 1, 5'd1, 32'h0BAD0002, 1, 0, 1, 0, 6'd2));
    applyRow(mk(1, 0, 6'd0, 0, 1, 32'h0BAD0003, 0, 0, 5'd0, 32'h0,        1, 0, 0, 0, 6'd0));
    applyRow(mk(0, 1, 6'd1, 0, 0, 32'h0,        1, 0, 5'd0, 32'h0,        1, 0, 1, 0, 6'd0));
    applyRow(mk(0, 0, 6'd0, 0, 1, 32'h00000013, 0, 1, 5'd0, 32'h00000013, 1, 0, 0, 0, 6'd1));
    applyRow(mk(0, 0, 6'd0, 0, 0, 32'h0,        0, 0, 5'd0, 32'h00000013, 0, 1, 0, 0, 6'd1));
    applyRow(mk(0, 0, 6'd0, 0, 0, 32'h0,        0, 0, 5'd0, 32'h00000013, 0, 1, 0, 0, 6'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
